// File: rtl/pkg_display.sv
// rtl/pkg_display.sv - shared glyphs and scan states for the 7-segment display controller
package pkg_display;

    typedef enum logic [1:0] {
        DESLIGADO = 2'd0,
        APAGADO   = 2'd1,
        MOSTRA    = 2'd2
    } estado_t;

    // Active-high patterns, segment a in bit 0 through g in bit 6.
    localparam logic [6:0] SEG_APAGADO = 7'h00;

    localparam logic [6:0] GLIFOS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/decodificador_7seg.sv
// rtl/decodificador_7seg.sv - hex nibble to active-high 7-segment glyph
module decodificador_7seg
    import pkg_display::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segmentos
);

    assign segmentos = GLIFOS[nibble];

endmodule

// File: rtl/controlador_varredura.sv
// rtl/controlador_varredura.sv - 4-digit multiplexed display scan with blanking, zero suppression and frame-aligned load
module controlador_varredura
    import pkg_display::*;
#(
    parameter int DIV_VARREDURA   = 50000,
    parameter int BLANK_CICLOS    = 500,
    parameter bit SEG_ATIVO_BAIXO = 1'b1,
    parameter bit ZERO_ESQ        = 1'b1
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        habilita,
    input  logic [15:0] dado,
    input  logic        atualiza,
    output logic        pendente,
    output logic        fim_quadro,
    output logic [3:0]  digito,
    output logic [6:0]  segmentos
);

    localparam int             CW        = $clog2(DIV_VARREDURA);
    localparam logic [CW-1:0]  ULTIMO    = CW'(DIV_VARREDURA - 1);
    localparam logic [CW-1:0]  FIM_BLANK = CW'(BLANK_CICLOS);
    localparam logic [6:0]     SEG_OFF   = SEG_ATIVO_BAIXO ? ~SEG_APAGADO : SEG_APAGADO;

    estado_t        estado, estado_n;
    logic [CW-1:0]  contador, contador_n;
    logic [1:0]     indice, indice_n;
    logic [15:0]    reg_display, reg_pendente;
    logic           fim_n, copia;
    logic [3:0]     nibble;
    logic [6:0]     glifo, padrao;
    logic [3:0]     apaga;
    logic           z3, z2, z1;
    logic [3:0]     digito_n;
    logic [6:0]     segmentos_n;

    always_comb begin
        estado_n   = estado;
        contador_n = contador;
        indice_n   = indice;
        fim_n      = 1'b0;
        if (!habilita) begin
            estado_n   = DESLIGADO;
            contador_n = '0;
            indice_n   = 2'd0;
        end else begin
            case (estado)
                DESLIGADO: begin
                    estado_n   = APAGADO;
                    contador_n = '0;
                    indice_n   = 2'd0;
                end
                default: begin
                    if (contador == ULTIMO) begin
                        contador_n = '0;
                        indice_n   = indice + 2'd1;
                        fim_n      = (indice == 2'd3);
                    end else begin
                        contador_n = contador + 1'b1;
                    end
                    estado_n = (contador_n < FIM_BLANK) ? APAGADO : MOSTRA;
                end
            endcase
        end
    end

    // A disabled display can take new data at any time since nothing is visible.
    assign copia = (estado == DESLIGADO) || fim_n;

    assign nibble = reg_display[{indice_n, 2'b00} +: 4];

    decodificador_7seg u_decod (
        .nibble    (nibble),
        .segmentos (glifo)
    );

    assign z3    = (reg_display[15:12] == 4'd0);
    assign z2    = (reg_display[11:8]  == 4'd0);
    assign z1    = (reg_display[7:4]   == 4'd0);
    assign apaga = ZERO_ESQ ? {z3, z3 & z2, z3 & z2 & z1, 1'b0} : 4'b0000;

    assign padrao = apaga[indice_n] ? SEG_APAGADO : glifo;

    always_comb begin
        digito_n    = 4'b0000;
        segmentos_n = SEG_OFF;
        if (estado_n == MOSTRA) begin
            digito_n    = 4'b0001 << indice_n;
            segmentos_n = SEG_ATIVO_BAIXO ? ~padrao : padrao;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado       <= APAGADO;
            contador     <= '0;
            indice       <= 2'd0;
            digito       <= 4'b0000;
            segmentos    <= SEG_OFF;
            fim_quadro   <= 1'b0;
            reg_display  <= 16'h0000;
            reg_pendente <= 16'h0000;
            pendente     <= 1'b0;
        end else begin
            estado     <= estado_n;
            contador   <= contador_n;
            indice     <= indice_n;
            digito     <= digito_n;
            segmentos  <= segmentos_n;
            fim_quadro <= fim_n;
            if (copia && pendente) begin
                reg_display <= reg_pendente;
                pendente    <= 1'b0;
            end
            // A same-edge strobe wins over the copy so the fresh word stays pending.
            if (atualiza) begin
                reg_pendente <= dado;
                pendente     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_controlador_varredura.sv
// tb/tb_controlador_varredura.sv - self-checking bench for controlador_varredura
module tb_controlador_varredura;

    localparam int DIV    = 8;
    localparam int BLANK  = 2;
    localparam int QUADRO = 4 * DIV;

    localparam logic [6:0] GLIFO [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clock = 1'b0;
    logic        reset;
    logic        habilita;
    logic [15:0] dado;
    logic        atualiza;
    logic        pendente;
    logic        fim_quadro;
    logic [3:0]  digito;
    logic [6:0]  segmentos;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    controlador_varredura #(
        .DIV_VARREDURA   (DIV),
        .BLANK_CICLOS    (BLANK),
        .SEG_ATIVO_BAIXO (1'b1),
        .ZERO_ESQ        (1'b1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .habilita   (habilita),
        .dado       (dado),
        .atualiza   (atualiza),
        .pendente   (pendente),
        .fim_quadro (fim_quadro),
        .digito     (digito),
        .segmentos  (segmentos)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", nome, got, exp, $time);
        end
    endtask

    // Reference model: time since enable, display word and a one-deep pending slot.
    bit          m_on;
    int          m_t;
    logic [15:0] m_disp, m_pend;
    bit          m_pv, m_fim, m_fim_n, m_copia;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_on = 1; m_t = 0; m_disp = 0; m_pend = 0; m_pv = 0; m_fim = 0;
        end else begin
            m_fim_n = habilita && m_on && ((m_t % QUADRO) == QUADRO - 1);
            m_copia = !m_on || m_fim_n;
            if (m_copia && m_pv) begin
                m_disp = m_pend;
                m_pv   = 0;
            end
            if (atualiza) begin
                m_pend = dado;
                m_pv   = 1;
            end
            if (!habilita) begin
                m_on = 0; m_t = 0;
            end else if (!m_on) begin
                m_on = 1; m_t = 0;
            end else begin
                m_t++;
            end
            m_fim = m_fim_n;
        end
    end

    function automatic logic [3:0] m_dig();
        if (!m_on || (m_t % DIV) < BLANK) return 4'b0000;
        return 4'(1 << ((m_t / DIV) % 4));
    endfunction

    function automatic logic [6:0] m_seg();
        int d, msd;
        if (!m_on || (m_t % DIV) < BLANK) return 7'h7F;
        d = (m_t / DIV) % 4;
        msd = 0;
        for (int i = 0; i < 4; i++)
            if (m_disp[4*i +: 4] != 4'd0) msd = i;
        if (d > msd) return 7'h7F;
        return ~GLIFO[m_disp[4*d +: 4]];
    endfunction

    always @(negedge clock) begin
        if (chk_on) begin
            check("mdl_digito", 16'(digito), 16'(m_dig()));
            check("mdl_segmentos", 16'(segmentos), 16'(m_seg()));
            check("mdl_fim_quadro", 16'(fim_quadro), 16'(m_fim));
            check("mdl_pendente", 16'(pendente), 16'(m_pv));
        end
    end

    typedef struct packed {
        logic [15:0]     dado;
        logic [3:0][6:0] e;
    } vetor_t;

    vetor_t tab [10];

    task automatic avanca(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic carrega(input logic [15:0] v);
        dado = v; atualiza = 1'b1;
        @(negedge clock);
        atualiza = 1'b0;
    endtask

    task automatic espera_copia();
        int n = 0;
        while (pendente && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("espera_pendente", 16'(pendente), 16'd0);
        check("copia_em_fim", 16'(fim_quadro), 16'd1);
    endtask

    task automatic espera_fim();
        int n = 0;
        while (!fim_quadro && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("espera_fim", 16'(fim_quadro), 16'd1);
    endtask

    task automatic quadro(input logic [3:0][6:0] e);
        for (int i = 0; i < QUADRO; i++) begin
            int d = i / DIV;
            int p = i % DIV;
            check("quadro_digito", 16'(digito), (p < BLANK) ? 16'd0 : 16'(1 << d));
            check("quadro_seg", 16'(segmentos), (p < BLANK) ? 16'h7F : 16'(7'(~e[d])));
            @(negedge clock);
        end
    endtask

    initial begin
        int n;
        tab[0] = '{16'h1234, {7'h06, 7'h5B, 7'h4F, 7'h66}};
        tab[1] = '{16'h0042, {7'h00, 7'h00, 7'h66, 7'h5B}};
        tab[2] = '{16'h00F0, {7'h00, 7'h00, 7'h71, 7'h3F}};
        tab[3] = '{16'h0000, {7'h00, 7'h00, 7'h00, 7'h3F}};
        tab[4] = '{16'hABCD, {7'h77, 7'h7C, 7'h39, 7'h5E}};
        tab[5] = '{16'hEF09, {7'h79, 7'h71, 7'h3F, 7'h6F}};
        tab[6] = '{16'h0578, {7'h00, 7'h6D, 7'h07, 7'h7F}};
        tab[7] = '{16'h1000, {7'h06, 7'h3F, 7'h3F, 7'h3F}};
        tab[8] = '{16'h0006, {7'h00, 7'h00, 7'h00, 7'h7D}};
        tab[9] = '{16'h0300, {7'h00, 7'h4F, 7'h3F, 7'h3F}};

        reset = 1'b1; habilita = 1'b1; atualiza = 1'b0; dado = 16'h0000;
        avanca(2);
        check("rst_digito", 16'(digito), 16'h0);
        check("rst_seg", 16'(segmentos), 16'h7F);
        check("rst_pendente", 16'(pendente), 16'h0);
        check("rst_fim", 16'(fim_quadro), 16'h0);
        reset = 1'b0;
        chk_on = 1'b1;

        for (int k = 0; k < 10; k++) begin
            carrega(tab[k].dado);
            espera_copia();
            quadro(tab[k].e);
        end

        check("fim_inicio_quadro", 16'(fim_quadro), 16'd1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!fim_quadro && n < 100);
        check("periodo_fim", 16'(n), 16'(QUADRO));

        carrega(16'h1234);
        espera_copia();
        quadro(tab[0].e);
        avanca(12);
        carrega(16'h0042);
        check("t2_pendente", 16'(pendente), 16'd1);
        check("t2_digito_antigo", 16'(digito), 16'b0010);
        check("t2_seg_antigo", 16'(segmentos), 16'h30);
        espera_copia();
        quadro(tab[1].e);

        carrega(16'hAAAA);
        avanca(5);
        carrega(16'h00F0);
        espera_copia();
        quadro(tab[2].e);

        carrega(16'h0578);
        avanca(30);
        dado = 16'h0006; atualiza = 1'b1;
        @(negedge clock);
        atualiza = 1'b0;
        check("t4_fim", 16'(fim_quadro), 16'd1);
        check("t4_pendente_mantem", 16'(pendente), 16'd1);
        quadro(tab[6].e);
        check("t4_pendente_limpo", 16'(pendente), 16'd0);
        check("t4_fim2", 16'(fim_quadro), 16'd1);
        quadro(tab[8].e);

        avanca(19);
        check("t5_digito2", 16'(digito), 16'b0100);
        habilita = 1'b0;
        @(negedge clock);
        check("t5_off_digito", 16'(digito), 16'h0);
        check("t5_off_seg", 16'(segmentos), 16'h7F);
        check("t5_off_fim", 16'(fim_quadro), 16'h0);
        carrega(16'h0300);
        check("t5_off_pend", 16'(pendente), 16'd1);
        @(negedge clock);
        check("t5_off_copia", 16'(pendente), 16'd0);
        habilita = 1'b1;
        @(negedge clock);
        check("t5_on_blank0", 16'(digito), 16'h0);
        @(negedge clock);
        check("t5_on_blank1", 16'(digito), 16'h0);
        @(negedge clock);
        check("t5_on_digito0", 16'(digito), 16'b0001);
        check("t5_on_seg0", 16'(segmentos), 16'h40);

        carrega(16'hBEEF);
        check("t6_pend_antes", 16'(pendente), 16'd1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_pend", 16'(pendente), 16'd0);
        check("t6_rst_digito", 16'(digito), 16'h0);
        check("t6_rst_seg", 16'(segmentos), 16'h7F);
        check("t6_rst_fim", 16'(fim_quadro), 16'h0);
        @(negedge clock);
        reset = 1'b0;
        espera_fim();
        quadro(tab[3].e);

        for (int c = 0; c < 3000; c++) begin
            habilita = ($urandom_range(0, 99) >= 4);
            atualiza = ($urandom_range(0, 7) == 0);
            dado     = 16'($urandom);
            @(negedge clock);
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
